// File: rtl/fetch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_redirect_ctrl
//
// Purpose:
//   Instruction-fetch front end. It issues in-order fetch requests to the
//   instruction memory, pairs each response with the PC it was fetched from,
//   and buffers instructions for decode. It also applies branch and jump
//   redirects from EX: it flushes the younger pipeline stages, discards
//   fetches that are already in flight, and restarts fetching at the target.
//   A misaligned redirect target sets a sticky flag and halts fetching until
//   reset.
//
// Parameters:
//   XLEN            address / PC width
//   RESET_PC        first fetch address after reset
//   MAX_OUTSTANDING limit on granted fetches plus buffered instructions (2..4)
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_B_J_result          00 none, 01 taken branch/JAL, 11 JALR, 10 none
//   i_valid_ex            EX holds a valid instruction
//   i_target              redirect target computed in EX
//   i_stall               decode cannot accept an instruction this cycle
//   o_imem_req/o_imem_addr/i_imem_gnt       fetch request handshake
//   i_imem_rvalid/i_imem_rdata              in-order fetch response
//   o_instr_valid/o_instr/o_instr_pc        instruction to decode
//   o_flush               kill IF/ID and ID/EX contents this cycle
//   o_misalign            sticky instruction-address-misaligned flag
// ---------------------------------------------------------------------------
module fetch_redirect_ctrl #(
    parameter int unsigned     XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [1:0]      i_B_J_result,
    input  logic            i_valid_ex,
    input  logic [XLEN-1:0] i_target,
    input  logic            i_stall,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [31:0]     i_imem_rdata,
    output logic            o_instr_valid,
    output logic [31:0]     o_instr,
    output logic [XLEN-1:0] o_instr_pc,
    output logic            o_flush,
    output logic            o_misalign
);

    // Counters span 0..MAX_OUTSTANDING; pointers index 0..MAX_OUTSTANDING-1.
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PW = $clog2(MAX_OUTSTANDING);
    localparam logic [CW:0] MAX_SUM = (CW + 1)'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALT
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic [CW-1:0]   out_cnt_q, out_cnt_d;
    logic [CW-1:0]   disc_q, disc_d;
    logic [CW-1:0]   buf_cnt_q, buf_cnt_d;
    logic [PW-1:0]   pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
    logic [PW-1:0]   buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
    logic            misalign_q, misalign_d;
    logic            req_hold_q, req_hold_d;

    // Pending-PC FIFO (PC of each granted, unreturned fetch) and the
    // instruction buffer feeding decode.
    logic [XLEN-1:0] pend_pc_q [MAX_OUTSTANDING];
    logic [XLEN-1:0] buf_pc_q  [MAX_OUTSTANDING];
    logic [31:0]     buf_ins_q [MAX_OUTSTANDING];

    logic            req;
    logic            gnt_fire;
    logic            rsp_ok;
    logic            redirect;
    logic            tgt_mis;
    logic            push_ins;
    logic            pop_ins;
    logic [XLEN-1:0] eff_tgt;
    logic [CW:0]     inflight_sum;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Request, handshake and redirect decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a value on every path
        // (defaults first), so no latch is inferred.
        eff_tgt = i_target;
        if (i_B_J_result == 2'b11) begin
            eff_tgt[0] = 1'b0;
        end
        tgt_mis  = (eff_tgt[1:0] != 2'b00);
        redirect = !i_rst && i_valid_ex && i_B_J_result[0] && (state_q != ST_HALT);

        // Discarded fetches still occupy a slot until their response returns.
        inflight_sum = {1'b0, out_cnt_q} + {1'b0, buf_cnt_q};

        req = 1'b0;
        case (state_q)
            // Once raised, the request is held until granted even if the
            // occupancy condition would no longer allow a new one.
            ST_RUN:   req = req_hold_q || (inflight_sum < MAX_SUM);
            ST_DRAIN: req = 1'b1;
            default:  req = 1'b0;
        endcase

        gnt_fire = req && i_imem_gnt;
        rsp_ok   = i_imem_rvalid && (out_cnt_q != '0);
        push_ins = rsp_ok && (disc_q == '0) && !redirect && (state_q != ST_HALT);
        pop_ins  = (buf_cnt_q != '0) && !i_stall;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        misalign_d = misalign_q;
        req_hold_d = req && !i_imem_gnt;

        out_cnt_d = out_cnt_q + CW'(gnt_fire) - CW'(rsp_ok);
        pend_wr_d = gnt_fire ? ptr_inc(pend_wr_q) : pend_wr_q;
        pend_rd_d = rsp_ok ? ptr_inc(pend_rd_q) : pend_rd_q;

        // On redirect everything still in flight after this edge is stale,
        // including a same-cycle grant and excluding a same-cycle response.
        // A grant taken in DRAIN fetched the old address, so it is stale too.
        if (redirect) begin
            disc_d = out_cnt_d;
        end else begin
            disc_d = disc_q - CW'(rsp_ok && (disc_q != '0))
                            + CW'(gnt_fire && (state_q == ST_DRAIN));
        end

        if (redirect) begin
            buf_cnt_d = '0;
            buf_wr_d  = '0;
            buf_rd_d  = '0;
        end else begin
            buf_cnt_d = buf_cnt_q + CW'(push_ins) - CW'(pop_ins);
            buf_wr_d  = push_ins ? ptr_inc(buf_wr_q) : buf_wr_q;
            buf_rd_d  = pop_ins ? ptr_inc(buf_rd_q) : buf_rd_q;
        end

        if (redirect) begin
            tgt_d = eff_tgt;
            if (tgt_mis) begin
                state_d    = ST_HALT;
                misalign_d = 1'b1;
                req_hold_d = 1'b0;
            end else if (req && !i_imem_gnt) begin
                // The old-address request must complete its handshake first.
                state_d = ST_DRAIN;
            end else begin
                pc_d    = eff_tgt;
                state_d = ST_RUN;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (gnt_fire) begin
                        pc_d = pc_q + XLEN'(4);
                    end
                end
                ST_DRAIN: begin
                    if (gnt_fire) begin
                        pc_d    = tgt_q;
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    req_hold_d = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (i_rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            tgt_q      <= '0;
            out_cnt_q  <= '0;
            disc_q     <= '0;
            buf_cnt_q  <= '0;
            pend_wr_q  <= '0;
            pend_rd_q  <= '0;
            buf_wr_q   <= '0;
            buf_rd_q   <= '0;
            misalign_q <= 1'b0;
            req_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            out_cnt_q  <= out_cnt_d;
            disc_q     <= disc_d;
            buf_cnt_q  <= buf_cnt_d;
            pend_wr_q  <= pend_wr_d;
            pend_rd_q  <= pend_rd_d;
            buf_wr_q   <= buf_wr_d;
            buf_rd_q   <= buf_rd_d;
            misalign_q <= misalign_d;
            req_hold_q <= req_hold_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------
    // NOTE: the storage arrays carry no reset; the counters and pointers
    // above are reset, and no entry is read before it has been written.
    always_ff @(posedge i_clk) begin
        if (!i_rst && gnt_fire) begin
            pend_pc_q[pend_wr_q] <= pc_q;
        end
        if (!i_rst && push_ins) begin
            buf_pc_q[buf_wr_q]  <= pend_pc_q[pend_rd_q];
            buf_ins_q[buf_wr_q] <= i_imem_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (forced to reset values while i_rst is high)
    // ------------------------------------------------------------------
    assign o_imem_req    = !i_rst && req;
    assign o_imem_addr   = i_rst ? RESET_PC : pc_q;
    assign o_flush       = redirect;
    assign o_instr_valid = !i_rst && (buf_cnt_q != '0);
    assign o_instr       = o_instr_valid ? buf_ins_q[buf_rd_q] : 32'h0;
    assign o_instr_pc    = o_instr_valid ? buf_pc_q[buf_rd_q] : RESET_PC;
    assign o_misalign    = !i_rst && misalign_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_redirect_ctrl
//
// Self-checking bench for fetch_redirect_ctrl. Every cycle the DUT outputs
// are compared against a transaction-level model. The model keeps a queue of
// in-flight fetches, each tagged stale or live, and a queue of buffered
// instructions. A small in-order memory model answers the fetches.
// ---------------------------------------------------------------------------
module tb_fetch_redirect_ctrl;

    localparam int          MAXO   = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [1:0]  i_B_J_result = 2'b00;
    logic        i_valid_ex = 1'b0;
    logic [31:0] i_target = 32'h0;
    logic        i_stall = 1'b0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt = 1'b0;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = 32'h0;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        o_flush;
    logic        o_misalign;

    always #5 clk = ~clk;

    fetch_redirect_ctrl #(
        .XLEN            (32),
        .RESET_PC        (RST_PC),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_B_J_result  (i_B_J_result),
        .i_valid_ex    (i_valid_ex),
        .i_target      (i_target),
        .i_stall       (i_stall),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_instr_valid (o_instr_valid),
        .o_instr       (o_instr),
        .o_instr_pc    (o_instr_pc),
        .o_flush       (o_flush),
        .o_misalign    (o_misalign)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] pc;
        logic        stale;
    } fetch_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } instr_t;

    fetch_t      m_fly[$];
    instr_t      m_iq[$];
    logic [31:0] m_pc;
    logic [31:0] m_tgt;
    bit          m_drain;
    bit          m_halt;
    bit          m_mis;

    logic [31:0] mem_q[$];      // addresses granted by the DUT, oldest first
    logic [31:0] delivered[$];  // PCs accepted by decode
    bit          obs_req, obs_flush, obs_mis;
    logic [31:0] obs_addr;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return ~a ^ 32'h1357_9BDF;
    endfunction

    task automatic model_reset();
        m_fly.delete();
        m_iq.delete();
        mem_q.delete();
        m_pc    = RST_PC;
        m_tgt   = 32'h0;
        m_drain = 1'b0;
        m_halt  = 1'b0;
        m_mis   = 1'b0;
    endtask

    // One clock cycle: drive inputs after the edge, compare at the negedge,
    // then advance the model to the state after the next rising edge.
    task automatic step(input bit rst, input bit vex, input logic [1:0] bj,
                        input logic [31:0] tgt, input bit stall, input bit gnt,
                        input bit rv);
        bit          req_e, flush_e, fire, rsp, pop;
        logic [31:0] eff;
        fetch_t      f;
        instr_t      e;
        @(posedge clk);
        #1;
        i_rst         = rst;
        i_valid_ex    = vex;
        i_B_J_result  = bj;
        i_target      = tgt;
        i_stall       = stall;
        i_imem_gnt    = gnt;
        i_imem_rvalid = rv;
        i_imem_rdata  = (mem_q.size() > 0) ? mem_data(mem_q[0]) : 32'h0BAD_0BAD;
        #4;
        obs_req   = o_imem_req;
        obs_addr  = o_imem_addr;
        obs_flush = o_flush;
        obs_mis   = o_misalign;
        if (rst) begin
            check("rst_imem_req",    32'(o_imem_req),    32'h0);
            check("rst_imem_addr",   o_imem_addr,        RST_PC);
            check("rst_instr_valid", 32'(o_instr_valid), 32'h0);
            check("rst_instr",       o_instr,            32'h0);
            check("rst_instr_pc",    o_instr_pc,         RST_PC);
            check("rst_flush",       32'(o_flush),       32'h0);
            check("rst_misalign",    32'(o_misalign),    32'h0);
            model_reset();
        end else begin
            req_e   = !m_halt && (m_drain || ((m_fly.size() + m_iq.size()) < MAXO));
            flush_e = vex && bj[0] && !m_halt;
            check("imem_req", 32'(o_imem_req), 32'(req_e));
            if (req_e) check("imem_addr", o_imem_addr, m_pc);
            check("flush", 32'(o_flush), 32'(flush_e));
            check("instr_valid", 32'(o_instr_valid), 32'(m_iq.size() > 0));
            if (m_iq.size() > 0) begin
                check("instr",    o_instr,    m_iq[0].ins);
                check("instr_pc", o_instr_pc, m_iq[0].pc);
            end
            check("misalign", 32'(o_misalign), 32'(m_mis));

            if (o_instr_valid && !stall) delivered.push_back(o_instr_pc);
            if (rv && mem_q.size() > 0) mem_q.delete(0);
            if (o_imem_req && gnt) mem_q.push_back(o_imem_addr);

            fire = req_e && gnt;
            rsp  = rv && (m_fly.size() > 0);
            pop  = (m_iq.size() > 0) && !stall;
            if (pop) m_iq.delete(0);
            if (rsp) begin
                f = m_fly.pop_front();
                if (!f.stale && !m_halt && !flush_e) begin
                    e.pc  = f.pc;
                    e.ins = mem_data(f.pc);
                    m_iq.push_back(e);
                end
            end
            if (fire) begin
                f.pc    = m_pc;
                f.stale = m_drain;
                m_fly.push_back(f);
            end
            eff = (bj == 2'b11) ? {tgt[31:1], 1'b0} : tgt;
            if (flush_e) begin
                for (int i = 0; i < m_fly.size(); i++) m_fly[i].stale = 1'b1;
                m_iq.delete();
                m_tgt = eff;
                if (eff[1:0] != 2'b00) begin
                    m_halt  = 1'b1;
                    m_mis   = 1'b1;
                    m_drain = 1'b0;
                end else if (req_e && !gnt) begin
                    m_drain = 1'b1;
                end else begin
                    m_pc    = eff;
                    m_drain = 1'b0;
                end
            end else if (fire) begin
                if (m_drain) begin
                    m_pc    = m_tgt;
                    m_drain = 1'b0;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic do_reset();
        step(1, 0, 2'b00, 32'h0, 0, 0, 0);
        step(1, 0, 2'b00, 32'h0, 0, 0, 0);
    endtask

    // Memory always ready; each response returns the cycle after its grant.
    task automatic run(input int n, input bit stall);
        for (int i = 0; i < n; i++) step(0, 0, 2'b00, 32'h0, stall, 1, mem_q.size() > 0);
    endtask

    task automatic expect_delivered(input string name, input int idx, input logic [31:0] exp);
        check(name, (idx < delivered.size()) ? delivered[idx] : 32'hDEAD_BEEF, exp);
    endtask

    // ------------------------------------------------------------------
    // Single-cycle redirect decode vectors, each applied right after reset
    // in the first fetch cycle with the grant high.
    // ------------------------------------------------------------------
    typedef struct {
        bit          vex;
        logic [1:0]  bj;
        logic [31:0] tgt;
        bit          exp_flush;
        bit          exp_req;
        bit          chk_addr;
        logic [31:0] exp_addr;
        bit          exp_mis;
    } vec_t;

    vec_t vecs[10];
    int   grants;
    int   reqs_in_halt;
    bit   rst_r, vex_r, stall_r, gnt_r, rv_r;
    logic [1:0]  bj_r;
    logic [31:0] tgt_r;

    initial begin
        vecs[0] = '{1, 2'b01, 32'h0000_0100, 1, 1, 1, 32'h0000_0100, 0};
        vecs[1] = '{1, 2'b11, 32'h0000_0301, 1, 1, 1, 32'h0000_0300, 0};
        vecs[2] = '{1, 2'b01, 32'h0000_0102, 1, 0, 0, 32'h0,         1};
        vecs[3] = '{0, 2'b01, 32'h0000_0100, 0, 1, 1, 32'h0000_0004, 0};
        vecs[4] = '{1, 2'b10, 32'h0000_0100, 0, 1, 1, 32'h0000_0004, 0};
        vecs[5] = '{1, 2'b00, 32'h0000_0100, 0, 1, 1, 32'h0000_0004, 0};
        vecs[6] = '{1, 2'b11, 32'h0000_0302, 1, 0, 0, 32'h0,         1};
        vecs[7] = '{1, 2'b11, 32'h0000_0303, 1, 0, 0, 32'h0,         1};
        vecs[8] = '{1, 2'b01, 32'hFFFF_FFFC, 1, 1, 1, 32'hFFFF_FFFC, 0};
        vecs[9] = '{1, 2'b11, 32'h0000_0001, 1, 1, 1, 32'h0000_0000, 0};

        model_reset();

        for (int v = 0; v < 10; v++) begin
            do_reset();
            step(0, vecs[v].vex, vecs[v].bj, vecs[v].tgt, 0, 1, 0);
            check("tbl_flush", 32'(obs_flush), 32'(vecs[v].exp_flush));
            step(0, 0, 2'b00, 32'h0, 0, 0, 0);
            check("tbl_next_req", 32'(obs_req), 32'(vecs[v].exp_req));
            if (vecs[v].chk_addr) check("tbl_next_addr", obs_addr, vecs[v].exp_addr);
            check("tbl_misalign", 32'(obs_mis), 32'(vecs[v].exp_mis));
            check("tbl_flush_low", 32'(obs_flush), 32'h0);
        end

        // Sequential fetch from reset, memory always ready.
        do_reset();
        delivered.delete();
        run(12, 0);
        for (int k = 0; k < 4; k++) expect_delivered("seq_pc", k, 32'(4 * k));

        // Decode stalled for several cycles: occupancy limit, nothing lost.
        do_reset();
        delivered.delete();
        grants = 0;
        for (int k = 0; k < 6; k++) begin
            step(0, 0, 2'b00, 32'h0, 1, 1, mem_q.size() > 0);
            if (obs_req) grants++;
        end
        check("stall_grants", 32'(grants), 32'(MAXO));
        check("stall_none_taken", 32'(delivered.size()), 32'h0);
        run(10, 0);
        for (int k = 0; k < 4; k++) expect_delivered("stall_release_pc", k, 32'(4 * k));

        // Redirect with two fetches granted and unreturned.
        do_reset();
        step(0, 0, 2'b00, 32'h0, 0, 1, 0);
        step(0, 0, 2'b00, 32'h0, 0, 1, 0);
        step(0, 1, 2'b01, 32'h0000_0100, 0, 0, 0);
        check("redir_flush", 32'(obs_flush), 32'h1);
        delivered.delete();
        step(0, 0, 2'b00, 32'h0, 0, 1, mem_q.size() > 0);
        check("redir_flush_one_cycle", 32'(obs_flush), 32'h0);
        run(8, 0);
        expect_delivered("redir_first_pc", 0, 32'h0000_0100);

        // Redirect while a request waits for grant: old address held, DRAIN.
        do_reset();
        step(0, 0, 2'b00, 32'h0, 0, 1, 0);
        step(0, 1, 2'b01, 32'h0000_0200, 0, 0, 0);
        check("drain_flush", 32'(obs_flush), 32'h1);
        for (int k = 0; k < 2; k++) begin
            step(0, 0, 2'b00, 32'h0, 0, 0, 0);
            check("drain_req_held", 32'(obs_req), 32'h1);
            check("drain_addr_held", obs_addr, 32'h0000_0004);
        end
        step(0, 0, 2'b00, 32'h0, 0, 1, 1);
        delivered.delete();
        run(8, 0);
        expect_delivered("drain_first_pc", 0, 32'h0000_0200);

        // JALR clears bit 0; misaligned JAL halts until reset.
        do_reset();
        step(0, 1, 2'b11, 32'h0000_0301, 0, 1, 0);
        delivered.delete();
        run(8, 0);
        expect_delivered("jalr_first_pc", 0, 32'h0000_0300);
        check("jalr_no_misalign", 32'(obs_mis), 32'h0);
        step(0, 1, 2'b01, 32'h0000_0102, 0, 1, mem_q.size() > 0);
        check("mis_flush", 32'(obs_flush), 32'h1);
        reqs_in_halt = 0;
        for (int k = 0; k < 6; k++) begin
            step(0, 0, 2'b00, 32'h0, 0, 1, mem_q.size() > 0);
            if (obs_req) reqs_in_halt++;
        end
        check("halt_no_req", 32'(reqs_in_halt), 32'h0);
        check("halt_misalign", 32'(obs_mis), 32'h1);
        step(0, 1, 2'b01, 32'h0000_0100, 0, 1, 0);
        check("halt_no_flush", 32'(obs_flush), 32'h0);
        do_reset();
        step(0, 0, 2'b00, 32'h0, 0, 0, 0);
        check("post_halt_misalign", 32'(obs_mis), 32'h0);
        check("post_halt_req", 32'(obs_req), 32'h1);

        // Grant, response and redirect in one cycle.
        do_reset();
        step(0, 0, 2'b00, 32'h0, 0, 1, 0);
        step(0, 1, 2'b01, 32'h0000_0400, 0, 1, 1);
        delivered.delete();
        run(8, 0);
        expect_delivered("same_cycle_first_pc", 0, 32'h0000_0400);

        // Reset mid-operation, then a stray response with nothing in flight.
        do_reset();
        step(0, 0, 2'b00, 32'h0, 0, 1, 0);
        step(0, 0, 2'b00, 32'h0, 0, 1, 0);
        do_reset();
        step(0, 0, 2'b00, 32'h0, 0, 0, 1);
        delivered.delete();
        run(6, 0);
        expect_delivered("after_reset_pc", 0, RST_PC);
        check("after_reset_no_stray", (delivered.size() > 0) ? 32'(o_instr != 32'h0BAD_0BAD) : 32'h1, 32'h1);

        // PC wraps through the top of the address space.
        do_reset();
        step(0, 1, 2'b01, 32'hFFFF_FFF8, 0, 1, 0);
        delivered.delete();
        run(14, 0);
        expect_delivered("wrap_pc0", 0, 32'hFFFF_FFF8);
        expect_delivered("wrap_pc1", 1, 32'hFFFF_FFFC);
        expect_delivered("wrap_pc2", 2, 32'h0000_0000);

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            rst_r   = ($urandom_range(0, 299) == 0) || (m_halt && ($urandom_range(0, 7) == 0));
            vex_r   = ($urandom_range(0, 5) == 0);
            bj_r    = 2'($urandom_range(0, 3));
            tgt_r   = $urandom;
            if ($urandom_range(0, 7) != 0) tgt_r[1:0] = 2'b00;
            stall_r = ($urandom_range(0, 2) == 0);
            gnt_r   = ($urandom_range(0, 2) != 0);
            rv_r    = (mem_q.size() > 0) && ($urandom_range(0, 2) != 0);
            step(rst_r, vex_r, bj_r, tgt_r, stall_r, gnt_r, rv_r);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_ctrl.md
FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

Interface
REQ-001 SHALL have parameter XLEN, 32, address/PC width.
REQ-002 SHALL have parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have parameter MAX_OUTSTANDING, 2, limit on granted fetches plus buffered instructions (2..4).
REQ-004 SHALL have port i_clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port i_rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port i_B_J_result  in  2  00 none, 01 taken branch/JAL, 11 JALR, 10 treated as none.
REQ-007 SHALL have port i_valid_ex  in  1  EX holds a valid instruction; i_B_J_result ignored when low.
REQ-008 SHALL have port i_target  in  XLEN  redirect target computed in EX.
REQ-009 SHALL have port i_stall  in  1  decode cannot accept an instruction this cycle.
REQ-010 SHALL have ports o_imem_req out 1, o_imem_addr out XLEN, i_imem_gnt in 1  fetch request handshake.
REQ-011 SHALL have ports i_imem_rvalid in 1, i_imem_rdata in 32  in-order fetch response.
REQ-012 SHALL have ports o_instr_valid out 1, o_instr out 32, o_instr_pc out XLEN  instruction to decode.
REQ-013 SHALL have port o_flush  out  1  kill IF/ID and ID/EX contents this cycle.
REQ-014 SHALL have port o_misalign  out  1  sticky instruction-address-misaligned flag.

Function
REQ-015 SHALL implement FSM states RUN, DRAIN, HALT; reset state RUN.
REQ-016 A redirect SHALL be i_valid_ex=1 and i_B_J_result[0]=1 in RUN or DRAIN.
REQ-017 For JALR (11) effective target SHALL be i_target with bit 0 cleared; otherwise i_target unchanged.
REQ-018 o_flush SHALL be combinational, high in exactly the redirect cycle, low otherwise and during i_rst.
REQ-019 In RUN, o_imem_req SHALL be high when outstanding+buffered < MAX_OUTSTANDING; o_imem_addr = PC.
REQ-020 Once raised, o_imem_req and o_imem_addr SHALL stay stable until the cycle i_imem_gnt=1.
REQ-021 On grant, PC SHALL advance by 4 (modulo 2^XLEN, wraps silently) and the granted PC SHALL be pushed into a pending-PC FIFO of depth MAX_OUTSTANDING.
REQ-022 Outstanding count SHALL +1 on grant, -1 on rvalid, hold when both in one cycle; rvalid with count 0 SHALL be ignored.
REQ-023 On rvalid with discard count 0, {pending PC, rdata} SHALL enter a MAX_OUTSTANDING-deep instruction buffer; head drives o_instr/o_instr_pc with o_instr_valid=1.
REQ-024 Buffer head SHALL pop when o_instr_valid=1 and i_stall=0; outputs SHALL hold unchanged while i_stall=1.
REQ-025 On redirect, the instruction buffer SHALL clear next edge and o_instr_valid SHALL be 0 in the following cycle.
REQ-026 On redirect, discard count SHALL load outstanding count (including a same-cycle grant, excluding a same-cycle rvalid); responses while discard>0 SHALL be dropped and decrement it.
REQ-027 On redirect with an ungranted request pending, the request SHALL be held to grant per REQ-020 and counted for discard.
REQ-028 Redirect target SHALL be latched; state SHALL go DRAIN if a request remains ungranted, else PC=target and stay RUN.
REQ-029 In DRAIN, on grant PC SHALL load latched target and state SHALL return to RUN; a newer redirect in DRAIN SHALL overwrite the latched target.
REQ-030 If effective target bits[1:0] != 00, o_misalign SHALL set next edge, state SHALL go HALT, no new requests SHALL issue; outstanding responses SHALL be discarded.
REQ-031 HALT SHALL be left only via i_rst; o_flush SHALL stay 0 in HALT.

Reset
REQ-032 While i_rst=1: o_imem_req, o_instr_valid, o_flush, o_misalign =0; o_imem_addr, o_instr_pc =RESET_PC; o_instr=0.
REQ-033 Reset SHALL clear PC to RESET_PC, all counters and FIFOs, latched target; state RUN; first request in cycle after i_rst falls.
REQ-034 Reset mid-operation SHALL abandon in-flight fetches; later rvalids SHALL be ignored per REQ-022.

Verification
REQ-035 Reset release, gnt tied 1, rvalid 1 cycle after gnt -> addresses 0,4,8,... ; o_instr_pc matches each o_instr.
REQ-036 i_stall=1 for 5 cycles, memory always ready -> at most MAX_OUTSTANDING (2) requests granted, o_instr stable, none lost on release.
REQ-037 Two granted, unreturned fetches, redirect 01 to 0x100 -> o_flush 1 cycle, both responses dropped, next o_instr_pc=0x100.
REQ-038 Redirect to 0x200 while req pending with gnt low 3 cycles -> old addr held, then DRAIN, next request addr 0x200, old response dropped.
REQ-039 JALR target 0x301 -> effective 0x300, no misalign; JAL target 0x102 -> o_misalign=1, o_imem_req stays 0 until i_rst.
REQ-040 Grant and rvalid same cycle with redirect -> discard count correct; no stale instruction reaches o_instr.
